// File: rtl/vp_fb_scheduler_if.sv
// Commit-to-feedback interface of vp_fb_scheduler: validation lanes in, predictor fb_* lanes out.
interface vp_fb_scheduler_if #(
    parameter int unsigned P_FIFO_DEPTH = 8
);
    localparam int unsigned OCC_W = $clog2(P_FIFO_DEPTH) + 1;

    logic                  init_req_i;
    logic [1:0][31:0]      in_pc_i;
    logic [1:0][31:0]      in_actual_i;
    logic [1:0]            in_mispredict_i;
    logic [1:0]            in_conf_i;
    logic [1:0]            in_valid_i;
    logic                  in_ready_o;
    logic [1:0][31:0]      fb_pc_o;
    logic [1:0][31:0]      fb_actual_o;
    logic [1:0]            fb_mispredict_o;
    logic [1:0]            fb_conf_o;
    logic [1:0]            fb_valid_o;
    logic                  busy_o;
    logic [OCC_W-1:0]      occupancy_o;

    modport slave (
        input  init_req_i, in_pc_i, in_actual_i, in_mispredict_i, in_conf_i, in_valid_i,
        output in_ready_o, fb_pc_o, fb_actual_o, fb_mispredict_o, fb_conf_o, fb_valid_o,
               busy_o, occupancy_o
    );

    modport master (
        output init_req_i, in_pc_i, in_actual_i, in_mispredict_i, in_conf_i, in_valid_i,
        input  in_ready_o, fb_pc_o, fb_actual_o, fb_mispredict_o, fb_conf_o, fb_valid_o,
               busy_o, occupancy_o
    );
endinterface

// File: rtl/vp_fb_scheduler.sv
// Feedback scheduler for the last-value predictor: table sweep on init, then in-order FIFO issue in pairs.
// Optional statistics counters are enabled with `define VP_FB_SCHED_STATS_EN.
module vp_fb_scheduler #(
    parameter int unsigned P_INDEX_WIDTH = 11,
    parameter int unsigned P_FIFO_DEPTH  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    vp_fb_scheduler_if.slave    bus
`ifdef VP_FB_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_pairs_o,
    output logic [31:0]         stat_singles_o,
    output logic [31:0]         stat_alias_splits_o
`endif
);

    localparam int unsigned PTR_W   = $clog2(P_FIFO_DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;
    localparam int unsigned SWEEP_W = P_INDEX_WIDTH - 1;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] actual;
        logic        mispredict;
        logic        conf;
    } entry_t;

    typedef struct packed {
        entry_t [1:0] lane;
        logic   [1:0] valid;
    } fb_t;

    logic [0:0]         state_q, state_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]   head_nxt_c, tail_nxt_c;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    fb_t                fb_q, fb_d;
    entry_t             mem_q [P_FIFO_DEPTH];
    entry_t             wr0_c, wr1_c, ent_a_c, ent_b_c;
    logic [1:0]         push_c, pop_c;
    logic               alias_c;

    assign head_nxt_c = head_q + PTR_W'(1);
    assign tail_nxt_c = tail_q + PTR_W'(1);
    assign ent_a_c    = mem_q[head_q];
    assign ent_b_c    = mem_q[head_nxt_c];
    assign wr0_c      = {bus.in_pc_i[0], bus.in_actual_i[0], bus.in_mispredict_i[0], bus.in_conf_i[0]};
    assign wr1_c      = {bus.in_pc_i[1], bus.in_actual_i[1], bus.in_mispredict_i[1], bus.in_conf_i[1]};

    // Next-state, push/pop and issue decision
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        fb_d    = '0;
        push_c  = 2'd0;
        pop_c   = 2'd0;
        alias_c = 1'b0;

        case (state_q)
            S_INIT: begin
                fb_d.valid   = 2'b11;
                fb_d.lane[0] = entry_t'{pc: 32'({sweep_q, 1'b0}), actual: 32'd0, mispredict: 1'b1, conf: 1'b0};
                fb_d.lane[1] = entry_t'{pc: 32'({sweep_q, 1'b1}), actual: 32'd0, mispredict: 1'b1, conf: 1'b0};
                sweep_d      = sweep_q + SWEEP_W'(1);
                if (&sweep_q) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (in_ready_q && (|bus.in_valid_i)) begin
                    push_c = bus.in_valid_i[1] ? 2'd2 : 2'd1;
                end
                if (occ_q == OCC_W'(1)) begin
                    fb_d.lane[0] = ent_a_c;
                    fb_d.valid   = 2'b01;
                    pop_c        = 2'd1;
                end else if (occ_q >= OCC_W'(2)) begin
                    // Same index with a different PC would collide inside the predictor
                    alias_c      = (ent_a_c.pc[P_INDEX_WIDTH-1:0] == ent_b_c.pc[P_INDEX_WIDTH-1:0]) &&
                                   (ent_a_c.pc != ent_b_c.pc);
                    fb_d.lane[0] = ent_a_c;
                    if (alias_c) begin
                        fb_d.valid = 2'b01;
                        pop_c      = 2'd1;
                    end else begin
                        fb_d.lane[1] = ent_b_c;
                        fb_d.valid   = 2'b11;
                        pop_c        = 2'd2;
                    end
                end
            end
        endcase

        if (bus.init_req_i) begin
            state_d = S_INIT;
            sweep_d = '0;
            fb_d    = '0;
            push_c  = 2'd0;
            pop_c   = 2'd0;
            alias_c = 1'b0;
        end

        head_d     = bus.init_req_i ? '0 : head_q + PTR_W'(pop_c);
        tail_d     = bus.init_req_i ? '0 : tail_q + PTR_W'(push_c);
        occ_d      = bus.init_req_i ? '0 : occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
        in_ready_d = (state_d == S_RUN) && (occ_d <= OCC_W'(P_FIFO_DEPTH - 2));
        busy_d     = (state_d == S_INIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_INIT;
            sweep_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fb_q       <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            fb_q       <= fb_d;
        end
    end

    // FIFO storage; lane 0 is written at the tail, lane 1 right behind it
    always_ff @(posedge clk_i) begin
        if (push_c != 2'd0) begin
            mem_q[tail_q] <= wr0_c;
        end
        if (push_c == 2'd2) begin
            mem_q[tail_nxt_c] <= wr1_c;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bus.fb_pc_o[i]         = fb_q.lane[i].pc;
            bus.fb_actual_o[i]     = fb_q.lane[i].actual;
            bus.fb_mispredict_o[i] = fb_q.lane[i].mispredict;
            bus.fb_conf_o[i]       = fb_q.lane[i].conf;
        end
    end

    assign bus.fb_valid_o  = fb_q.valid;
    assign bus.in_ready_o  = in_ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.occupancy_o = occ_q;

`ifdef VP_FB_SCHED_STATS_EN
    logic [31:0] pairs_q, singles_q, splits_q;

    // Saturating issue statistics, counted only for RUN-state issue cycles
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.init_req_i) begin
            pairs_q   <= '0;
            singles_q <= '0;
            splits_q  <= '0;
        end else if (state_q == S_RUN) begin
            if ((fb_d.valid == 2'b11) && (pairs_q != '1)) begin
                pairs_q <= pairs_q + 32'd1;
            end
            if ((fb_d.valid == 2'b01) && (singles_q != '1)) begin
                singles_q <= singles_q + 32'd1;
            end
            if (alias_c && (splits_q != '1)) begin
                splits_q <= splits_q + 32'd1;
            end
        end
    end

    assign stat_pairs_o        = pairs_q;
    assign stat_singles_o      = singles_q;
    assign stat_alias_splits_o = splits_q;
`endif

endmodule

// File: tb/tb_vp_fb_scheduler.sv
// Scoreboard bench for vp_fb_scheduler: expected feedback stream in a queue, negedge monitor compares.
module tb_vp_fb_scheduler;
    localparam int unsigned IW    = 3;
    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] actual;
        logic        mis;
        logic        conf;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vp_fb_scheduler_if #(.P_FIFO_DEPTH(DEPTH)) bus();

    vp_fb_scheduler #(.P_INDEX_WIDTH(IW), .P_FIFO_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pairs_seen = 0;
    int   singles_seen = 0;
    bit   seen_stall = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] actual, input logic mis, input logic conf);
        ent_t e;
        e.pc = pc; e.actual = actual; e.mis = mis; e.conf = conf;
        return e;
    endfunction

    function automatic bit aliased(input logic [31:0] a, input logic [31:0] b);
        return (a[IW-1:0] == b[IW-1:0]) && (a != b);
    endfunction

    // A sweep clears every index: pcs 0..2^IW-1 as mispredicted zero values
    task automatic push_sweep();
        exp_q.delete();
        for (int k = 0; k < (1 << IW); k++) exp_q.push_back(mk(32'(k), 32'd0, 1'b1, 1'b0));
    endtask

    always @(negedge clk) begin
        logic [1:0] v;
        ent_t got, e;
        if (!rst) begin
            v = bus.fb_valid_o;
            chk("occupancy_bound", 128'(bus.occupancy_o <= DEPTH), 128'd1);
            if (!bus.busy_o && !bus.in_ready_o) seen_stall = 1'b1;
            if (v == 2'b11) pairs_seen++;
            if (v == 2'b01) singles_seen++;
            if (v != 2'b00) begin
                chk("fb_valid_shape", 128'(v == 2'b10), 128'd0);
                for (int l = 0; l < 2; l++) begin
                    if (v[l]) begin
                        got = mk(bus.fb_pc_o[l], bus.fb_actual_o[l], bus.fb_mispredict_o[l], bus.fb_conf_o[l]);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_issue_pc", 128'(got.pc), 128'hDEAD);
                        end else begin
                            e = exp_q.pop_front();
                            chk("issue_pc", 128'(got.pc), 128'(e.pc));
                            chk("issue_payload", 128'({got.actual, got.mis, got.conf}), 128'({e.actual, e.mis, e.conf}));
                        end
                    end
                end
                if (v == 2'b11)
                    chk("pair_not_aliased", 128'(aliased(bus.fb_pc_o[0], bus.fb_pc_o[1])), 128'd0);
            end
        end
    end

    // One cycle of stimulus; the scoreboard learns of an enqueue only after the edge that accepts it
    task automatic step(input logic [1:0] v, input ent_t e0, input ent_t e1, input logic init);
        bit acc;
        bus.in_valid_i      = v;
        bus.in_pc_i[0]      = e0.pc;     bus.in_pc_i[1]      = e1.pc;
        bus.in_actual_i[0]  = e0.actual; bus.in_actual_i[1]  = e1.actual;
        bus.in_mispredict_i = {e1.mis, e0.mis};
        bus.in_conf_i       = {e1.conf, e0.conf};
        bus.init_req_i      = init;
        acc = bus.in_ready_o && (v != 2'b00) && !init;
        @(posedge clk); #1;
        bus.in_valid_i = 2'b00;
        bus.init_req_i = 1'b0;
        if (init) push_sweep();
        else if (acc) begin
            exp_q.push_back(e0);
            if (v[1]) exp_q.push_back(e1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, '0, '0, 1'b0);
    endtask

    task automatic send(input logic [1:0] v, input ent_t e0, input ent_t e1);
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready_o) begin
                step(v, e0, e1, 1'b0);
                return;
            end
            idle(1);
        end
        chk("send_timeout", 128'd1, 128'd0);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk(nm, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int s0, p0;
        ent_t a, b;
        logic [1:0] v;
        bus.init_req_i = 1'b0; bus.in_valid_i = 2'b00;
        bus.in_pc_i = '0; bus.in_actual_i = '0; bus.in_mispredict_i = '0; bus.in_conf_i = '0;

        repeat (2) @(posedge clk); #1;
        chk("rst_fb_valid", 128'(bus.fb_valid_o), 128'd0);
        chk("rst_fb_pc", 128'(bus.fb_pc_o), 128'd0);
        chk("rst_fb_misc", 128'({bus.fb_actual_o, bus.fb_mispredict_o, bus.fb_conf_o}), 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready_o), 128'd0);
        chk("rst_busy", 128'(bus.busy_o), 128'd1);
        chk("rst_occupancy", 128'(bus.occupancy_o), 128'd0);
        push_sweep();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("sweep_busy", 128'(bus.busy_o), 128'd1);
        chk("sweep_not_ready", 128'(bus.in_ready_o), 128'd0);
        drain("initial_sweep");
        idle(1);
        chk("run_busy", 128'(bus.busy_o), 128'd0);
        chk("run_ready", 128'(bus.in_ready_o), 128'd1);

        p0 = pairs_seen;
        send(2'b11, mk(32'h10, 32'h1111, 1'b0, 1'b1), mk(32'h24, 32'h2222, 1'b1, 1'b0));
        drain("pair_drain");
        idle(1);
        chk("pair_count", 128'(pairs_seen - p0), 128'd1);
        chk("pair_occ_zero", 128'(bus.occupancy_o), 128'd0);

        s0 = singles_seen;
        send(2'b11, mk(32'h08, 32'h3, 1'b1, 1'b0), mk(32'h48, 32'h4, 1'b0, 1'b0));
        drain("alias_drain");
        idle(1);
        chk("alias_singles", 128'(singles_seen - s0), 128'd2);

        p0 = pairs_seen;
        send(2'b11, mk(32'h30, 32'd5, 1'b0, 1'b1), mk(32'h30, 32'd6, 1'b0, 1'b1));
        drain("same_pc_drain");
        idle(1);
        chk("same_pc_pair", 128'(pairs_seen - p0), 128'd1);

        seen_stall = 1'b0;
        for (int i = 0; i < 8; i++)
            send(2'b11, mk(32'h200 + 32'(i << 8), 32'(i), 1'b1, 1'b0), mk(32'h208 + 32'(i << 8), 32'(i + 100), 1'b0, 1'b1));
        drain("backpressure_drain");
        chk("backpressure_stall", 128'(seen_stall), 128'd1);

        for (int i = 0; i < 20 && bus.occupancy_o < 6; i++)
            send(2'b11, mk(32'h500 + 32'(i << 8), 32'(i), 1'b0, 1'b0), mk(32'h508 + 32'(i << 8), 32'(i), 1'b0, 1'b0));
        chk("fill_reached", 128'(bus.occupancy_o >= 6), 128'd1);
        step(2'b11, mk(32'hBAD0, 32'd1, 1'b0, 1'b0), mk(32'hBAD1, 32'd2, 1'b0, 1'b0), 1'b1);
        chk("init_occ_zero", 128'(bus.occupancy_o), 128'd0);
        chk("init_busy", 128'(bus.busy_o), 128'd1);
        drain("init_sweep");

        step(2'b00, '0, '0, 1'b1);
        idle(2);
        step(2'b00, '0, '0, 1'b1);
        drain("restart_sweep");
        idle(1);

        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            a = mk(32'h4000 + 32'($urandom_range(0, 7) * 4), $urandom, 1'($urandom), 1'($urandom));
            b = mk(32'h4000 + 32'($urandom_range(0, 7) * 4), $urandom, 1'($urandom), 1'($urandom));
            step(v, a, b, ($urandom_range(0, 49) == 0));
        end
        drain("random_drain");

        send(2'b11, mk(32'h708, 32'd7, 1'b1, 1'b1), mk(32'h748, 32'd8, 1'b1, 1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        push_sweep();
        chk("midrst_fb_valid", 128'(bus.fb_valid_o), 128'd0);
        chk("midrst_occ", 128'(bus.occupancy_o), 128'd0);
        chk("midrst_busy", 128'(bus.busy_o), 128'd1);
        chk("midrst_ready", 128'(bus.in_ready_o), 128'd0);
        rst = 1'b0;
        drain("midrst_sweep");
        idle(3);
        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vp_fb_scheduler.md
Name: vp_fb_scheduler

Overview:
- Sits between the commit/validation stage and the last-value predictor's feedback (fb_*) ports.
- After reset, or on request, sweeps every table index to clear the value and confidence tables.
- In normal operation it buffers up to 2 validation results per cycle in an in-order FIFO, then issues them as pairs on the predictor's 2 feedback lanes.
- A pair is split whenever the two oldest entries alias to the same table index but carry different PCs.

Parameters:
- P_INDEX_WIDTH, 11, number of PC LSBs that index the predictor tables; the sweep covers 2^P_INDEX_WIDTH indices.
- P_FIFO_DEPTH, 8, number of FIFO entries; must be a power of 2 and >= 4.

Ports:
- clk_i  in  1  main clock
- rst_i  in  1  synchronous, active-high reset
- init_req_i  in  1  pulse: discard FIFO contents and re-run the table sweep
- in_pc_i  in  2x32  validated instruction PC per lane
- in_actual_i  in  2x32  true execution result per lane
- in_mispredict_i  in  2  misprediction flag per lane
- in_conf_i  in  2  saturated-confidence flag per lane
- in_valid_i  in  2  lane valid; lane 0 is older; 2'b10 is illegal
- in_ready_o  out  1  FIFO accepts this cycle
- fb_pc_o  out  2x32  to predictor fb_pc_i
- fb_actual_o  out  2x32  to predictor fb_actual_i
- fb_mispredict_o  out  2  to predictor fb_mispredict_i
- fb_conf_o  out  2  to predictor fb_conf_i
- fb_valid_o  out  2  to predictor fb_valid_i
- busy_o  out  1  high while in INIT state
- occupancy_o  out  $clog2(P_FIFO_DEPTH)+1  number of valid FIFO entries

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - State = INIT, sweep counter = 0, FIFO empty.
  - All fb_* outputs = 0, in_ready_o = 0, busy_o = 1, occupancy_o = 0.
- State INIT:
  - Each cycle drive fb_valid_o=2'b11, fb_pc_o[0]=2k, fb_pc_o[1]=2k+1 (zero-extended), fb_actual_o=0, fb_mispredict_o=2'b11, fb_conf_o=0, where k is the sweep counter.
  - The counter increments by 1 per cycle.
  - After the cycle with k = 2^(P_INDEX_WIDTH-1)-1, move to RUN.
  - The sweep takes exactly 2^(P_INDEX_WIDTH-1) cycles; in_ready_o = 0 throughout.
- State RUN:
  - in_ready_o = 1 when free entries >= 2. This is registered-free and depends only on occupancy, never on in_valid_i.
  - Enqueue when in_ready_o & |in_valid_i. Lane 0 is written first; one or two entries are added.
- Issue decision, taken each cycle from the oldest entries A (head) and B (head+1), qualified by occupancy:
  - occupancy 0: fb_valid_o=0 next cycle.
  - occupancy 1: issue A on lane 0; fb_valid_o=2'b01.
  - occupancy >= 2, and B.pc[P_INDEX_WIDTH-1:0] != A.pc[P_INDEX_WIDTH-1:0] or B.pc == A.pc: issue A on lane 0 and B on lane 1; fb_valid_o=2'b11; pop 2. Identical PCs go out together because the predictor merges them.
  - occupancy >= 2, indices equal and PCs differ (alias): issue A only, fb_valid_o=2'b01, pop 1. B issues in a later cycle.
- Latency and outputs:
  - fb_* outputs are registered.
  - An entry enqueued in cycle t is issued on fb_* no earlier than t+1. With an empty FIFO and no alias, it issues exactly at t+1.
  - Enqueue and dequeue in the same cycle are allowed; occupancy_o = old + pushed - popped.
  - Order is strictly preserved; entries are never dropped or reordered.
- init_req_i:
  - In RUN: in the next cycle clear the FIFO, zero the counter, enter INIT. Entries not yet issued are discarded.
  - In INIT: restart the sweep from k=0.
  - If asserted in the same cycle as an enqueue, init_req_i wins and the enqueue is discarded.
- Reset mid-operation (INIT or RUN): behaves exactly as the power-on reset values above.
- Pointers wrap modulo P_FIFO_DEPTH. occupancy_o never exceeds P_FIFO_DEPTH.

Optional Feature:
- Macro: VP_FB_SCHED_STATS_EN
- Defined:
  - Adds outputs stat_pairs_o[31:0], stat_singles_o[31:0], stat_alias_splits_o[31:0].
  - They count RUN cycles issuing 2'b11, cycles issuing 2'b01, and cycles where a split occurred due to aliasing.
  - All three reset to 0 on rst_i or init_req_i and saturate at 32'hFFFF_FFFF.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- P_INDEX_WIDTH=3, release reset -> 4 cycles of fb_valid_o=2'b11 with pc pairs (0,1),(2,3),(4,5),(6,7), mispredict=2'b11, busy_o=1; then busy_o=0, in_ready_o=1.
- RUN, empty FIFO, enqueue lanes pc 0x10 and 0x24 (index 0 and 4), valid 2'b11 -> next cycle fb_valid_o=2'b11, fb_pc_o=(0x10,0x24), occupancy_o back to 0.
- Enqueue pc 0x08 and 0x48 (P_INDEX_WIDTH=3, both index 0, different PC) -> cycle t+1 fb_valid_o=2'b01 pc 0x08; t+2 fb_valid_o=2'b01 pc 0x48.
- Enqueue pc 0x30 twice, actual 5 and 6 -> single cycle fb_valid_o=2'b11, both lanes pc 0x30, actuals 5 and 6.
- Enqueue 2/cycle for 5 cycles of aliased pairs -> in_ready_o drops when occupancy_o > P_FIFO_DEPTH-2 = 6; occupancy never exceeds 8; all entries issue in order.
- Fill FIFO to 6, pulse init_req_i -> occupancy_o=0 next cycle, busy_o=1, full 4-cycle sweep from pc 0, no stale entry is ever issued.
